// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx - 8N1 UART receiver.
//
// Brings the asynchronous serial line into the clk domain through a 2-flop
// synchroniser. It confirms the start bit at its middle, then samples each data
// bit (LSB first) and the stop bit at their middles. A good frame updates
// data_out and pulses data_valid for one cycle. A low stop bit pulses
// frame_error for one cycle, leaves data_out alone, and then waits for the line
// to go idle before it looks for another start bit.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   rx           in   serial line, idle high, asynchronous to clk
//   data_out     out  [7:0] last correctly framed byte, held until the next good frame
//   data_valid   out  one-cycle pulse when data_out has just been updated
//   frame_error  out  one-cycle pulse when the stop bit was sampled low
//   busy         out  high whenever the receiver is not idle
//
// Handshake: there is no back-pressure. data_valid is a one-cycle strobe, and a
// consumer that wants the byte must capture data_out in that cycle. It may also
// read data_out later, because the value is held until the next good frame.
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, ferr_n;

  // Both synchroniser flops reset to the idle level, so reset does not create
  // a fake start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_out    <= data_n;
      data_valid  <= valid_n;
      frame_error <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_out;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end

      // Re-check the line half a bit after the falling edge. If it is high
      // again, the edge was a glitch and not a start bit.
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      // From here every sample is one full bit-time after the previous one,
      // so each sample stays at the middle of its bit.
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n        = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      // The FSM leaves STOP at mid-stop-bit, so a start bit that follows
      // straight after the stop bit is still seen.
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      // The line is held low (a break or a broken frame). Do not treat it as
      // a new start bit until the line has gone high once.
      S_BREAK: begin
        clk_cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  // A fast baud rate keeps frames short: 20 clocks per bit at 50 MHz.
  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 2_500_000;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
  localparam int BIT_NS     = CPB * 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard entry: {frame_error expected, data_out expected}
  logic [8:0] exp_q[$];
  int         vt_q[$];
  logic [7:0] last_good = 8'h00;
  logic [8:0] mon_e;

  uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Reference model: a frame with a good stop bit gives its byte. A frame with
  // a low stop bit gives an error, and the last good byte is still shown.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int bit_ns);
    exp_q.push_back(stop_ok ? {1'b0, b} : {1'b1, last_good});
    if (stop_ok) last_good = b;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_ok;
    #(bit_ns);
    if (stop_ok) rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(n * BIT_NS);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, 9'(exp_q.size()), 9'd0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_error)) begin
      if (data_valid && frame_error) begin
        check("valid_and_ferr_together", 9'd1, 9'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_pulse", {frame_error, data_out}, 9'h1ff);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_result", {frame_error, data_out}, mon_e);
      end
      if (data_valid) vt_q.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out", {1'b0, data_out}, 9'h000);
    check("reset_valid", {8'b0, data_valid}, 9'd0);
    check("reset_ferr", {8'b0, frame_error}, 9'd0);
    check("reset_busy", {8'b0, busy}, 9'd0);

    // 1: single frame 0x55, busy during and idle after mid-stop
    fork
      send_frame(8'h55, 1'b1, BIT_NS);
      begin #(5 * BIT_NS); check("t1_busy_mid", {8'b0, busy}, 9'd1); end
    join
    check("t1_busy_after_stop", {8'b0, busy}, 9'd0);
    wait_drain("t1_drain");

    // 2: back-to-back frames with no gap, pulses exactly 10 bit-times apart
    idle_bits(2);
    vt_q.delete();
    @(negedge clk);
    send_frame(8'hA3, 1'b1, BIT_NS);
    send_frame(8'h00, 1'b1, BIT_NS);
    wait_drain("t2_drain");
    check("t2_pulse_count", 9'(vt_q.size()), 9'd2);
    if (vt_q.size() == 2) check("t2_spacing", 9'(vt_q[1] - vt_q[0]), 9'(10 * CPB));

    // 3: short low glitch is rejected at the start-bit check
    idle_bits(2);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("t3_busy_during", {8'b0, busy}, 9'd1);
    repeat (CPB) @(negedge clk);
    check("t3_busy_after", {8'b0, busy}, 9'd0);
    check("t3_data_held", {1'b0, data_out}, {1'b0, last_good});

    // 4: bad stop bit, line held low, then recovery
    idle_bits(2);
    @(negedge clk);
    send_frame(8'h3C, 1'b0, BIT_NS);
    #(BIT_NS);
    check("t4_busy_in_break", {8'b0, busy}, 9'd1);
    check("t4_data_held", {1'b0, data_out}, 9'h000);
    #(2 * BIT_NS);
    check("t4_busy_still", {8'b0, busy}, 9'd1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_busy_released", {8'b0, busy}, 9'd0);
    idle_bits(1);
    send_frame(8'hFF, 1'b1, BIT_NS);
    wait_drain("t4_drain");

    // 5: asynchronous reset in the middle of data bit 4 of 0x81
    idle_bits(2);
    @(negedge clk);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h81 >> i);
      #(BIT_NS);
    end
    rx = 1'b0;
    #(BIT_NS / 2 + 3);
    rst = 1'b1;
    #1;
    check("t5_rst_data_out", {1'b0, data_out}, 9'h000);
    check("t5_rst_valid", {8'b0, data_valid}, 9'd0);
    check("t5_rst_ferr", {8'b0, frame_error}, 9'd0);
    check("t5_rst_busy", {8'b0, busy}, 9'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    @(negedge clk);
    send_frame(8'h81, 1'b1, BIT_NS);
    wait_drain("t5_drain");

    // 6: baud mismatch of +3% and -3%
    idle_bits(2);
    @(negedge clk);
    send_frame(8'h5A, 1'b1, BIT_NS * 103 / 100);
    idle_bits(2);
    send_frame(8'h5A, 1'b1, BIT_NS * 97 / 100);
    wait_drain("t6_drain");

    // 7: random bytes, random bad stop bits, gaps and +/-2% rate
    idle_bits(2);
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic       ok;
      int         gap, bns;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 2);
      bns = BIT_NS - 8 + $urandom_range(0, 16);
      send_frame(b, ok, bns);
      if (!ok) begin
        #(bns);
        if (gap == 0) gap = 1;
      end
      if (gap != 0) idle_bits(gap);
    end
    idle_bits(1);
    wait_drain("t7_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
